// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: schedules up to Write_Port register-file writes per cycle
// from Num_Req requesters, round-robin, with same-cycle address conflicts held back.
module wb_port_arbiter #(
   parameter int Num_Req    = 6,
   parameter int Write_Port = 4,
   parameter int Width      = 32,
   parameter int Depth      = 64
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic [Num_Req-1:0]        Req_Valid,
   input  logic [$clog2(Depth)-1:0]  Req_Addr [Num_Req],
   input  logic [Width-1:0]          Req_Data [Num_Req],
   output logic [Num_Req-1:0]        Req_Ready,
   output logic [Write_Port-1:0]     We,
   output logic [$clog2(Depth)-1:0]  WA [Write_Port],
   output logic [Width-1:0]          WD [Write_Port]
);

   localparam int AW = $clog2(Depth);
   localparam int IW = (Num_Req > 1) ? $clog2(Num_Req) : 1;

   logic [IW-1:0]       ptr_r;
   logic [IW-1:0]       idx_s;
   logic [IW-1:0]       last_s;
   logic [Num_Req-1:0]  ready_s;
   logic [Write_Port-1:0] sel_we_s;
   logic [AW-1:0]       sel_addr_s [Write_Port];
   logic [Width-1:0]    sel_data_s [Write_Port];
   logic                conflict_s;
   logic                placed_s;
   logic                moved_s;

   // Requester index base+off, wrapped into 0..Num_Req-1 (off < Num_Req).
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= Num_Req) begin
         sum = sum - Num_Req;
      end else begin
         sum = sum + 0;
      end
      return IW'(sum);
   endfunction

   // Round-robin scan from ptr_r: drop register-0 writes, hold back duplicate
   // addresses, and pack the rest onto the lowest free ports.
   always_comb begin
      ready_s    = '0;
      sel_we_s   = '0;
      sel_addr_s = '{default: '0};
      sel_data_s = '{default: '0};
      idx_s      = ptr_r;
      last_s     = ptr_r;
      conflict_s = 1'b0;
      placed_s   = 1'b0;
      moved_s    = 1'b0;
      for (int k = 0; k < Num_Req; k++) begin
         idx_s      = wrap_add(ptr_r, k);
         conflict_s = 1'b0;
         placed_s   = 1'b0;
         if (Req_Valid[idx_s]) begin
            if (Req_Addr[idx_s] == {AW{1'b0}}) begin
               ready_s[idx_s] = 1'b1;
            end else begin
               for (int p = 0; p < Write_Port; p++) begin
                  if (sel_we_s[p] && (sel_addr_s[p] == Req_Addr[idx_s])) begin
                     conflict_s = 1'b1;
                  end else begin
                     conflict_s = conflict_s;
                  end
               end
               for (int p = 0; p < Write_Port; p++) begin
                  if (!conflict_s && !placed_s && !sel_we_s[p]) begin
                     sel_we_s[p]   = 1'b1;
                     sel_addr_s[p] = Req_Addr[idx_s];
                     sel_data_s[p] = Req_Data[idx_s];
                     placed_s      = 1'b1;
                  end else begin
                     placed_s = placed_s;
                  end
               end
               if (placed_s) begin
                  ready_s[idx_s] = 1'b1;
                  moved_s        = 1'b1;
                  last_s         = idx_s;
               end else begin
                  ready_s[idx_s] = 1'b0;
               end
            end
         end else begin
            ready_s[idx_s] = 1'b0;
         end
      end
      if (Rst) begin
         Req_Ready = '0;
      end else begin
         Req_Ready = ready_s;
      end
   end

   // Pointer advance and output registers; reset also drops any pending write.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         ptr_r <= '0;
         We    <= '0;
         WA    <= '{default: '0};
         WD    <= '{default: '0};
      end else begin
         if (moved_s) begin
            ptr_r <= wrap_add(last_s, 1);
         end else begin
            ptr_r <= ptr_r;
         end
         We <= sel_we_s;
         WA <= sel_addr_s;
         WD <= sel_data_s;
      end
   end

endmodule
